// File: rtl/down_count_ctrl.sv
// down_count_ctrl
//   Sequencer for the 4-bit down-counter datapath. The count-rate tick is a
//   clock enable produced by an internal prescaler (no derived clocks). Its
//   period is selected by I_M: slow (SLOW_DIV cycles) or fast (FAST_DIV cycles).
//   A load/run/pause/done FSM presets the count, decrements it once per tick
//   and terminates at zero. Optionally it reloads automatically from DONE.
//
// Ports
//   I_CLK          system clock, all logic on posedge
//   I_RST_N        asynchronous reset, active-low
//   I_START        level; starts or reloads from IDLE or DONE
//   I_PAUSE        level; freezes count and prescaler while high
//   I_CLEAR        level; synchronous return to IDLE with count cleared
//   I_M            rate select: 1 = SLOW_DIV, 0 = FAST_DIV
//   I_AUTO_RELOAD  1: DONE goes straight back to LOAD
//   I_LOAD_VAL     preset value captured in LOAD
//   O_COUNT        current count
//   O_TICK         1-cycle pulse on each decrement
//   O_DONE         1-cycle pulse on entry to DONE
//   O_BUSY         high in LOAD, RUN, PAUSED
//   O_STATE        IDLE=0 LOAD=1 RUN=2 PAUSED=3 DONE=4
//   All outputs come straight from flops.

module down_count_ctrl #(
  parameter int WIDTH    = 4,
  parameter int SLOW_DIV = 25000000,
  parameter int FAST_DIV = 12500000,
  parameter int PS_W     = 32
) (
  input  logic             I_CLK,
  input  logic             I_RST_N,
  input  logic             I_START,
  input  logic             I_PAUSE,
  input  logic             I_CLEAR,
  input  logic             I_M,
  input  logic             I_AUTO_RELOAD,
  input  logic [WIDTH-1:0] I_LOAD_VAL,
  output logic [WIDTH-1:0] O_COUNT,
  output logic             O_TICK,
  output logic             O_DONE,
  output logic             O_BUSY,
  output logic [2:0]       O_STATE
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_PAUSED = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [PS_W-1:0] SLOW_LAST = PS_W'(SLOW_DIV - 1);
  localparam logic [PS_W-1:0] FAST_LAST = PS_W'(FAST_DIV - 1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic [PS_W-1:0]   ps_q, ps_d;
  logic              m_q, m_d;
  logic              tick_q, tick_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              rate_change;
  logic [PS_W-1:0]   div_last;

  // The registered rate copy decides the active divider. In the one cycle
  // where I_M disagrees with it, the current tick period is restarted.
  assign rate_change = (m_q != I_M);
  assign div_last    = m_q ? SLOW_LAST : FAST_LAST;

  // Next-state logic. Priority is clear, then pause, then start. A tick that
  // falls due while pausing is not lost: the prescaler simply stays at its
  // last value, so the tick fires on the first RUN cycle after the pause.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ps_d    = ps_q;
    m_d     = I_M;
    tick_d  = 1'b0;
    done_d  = 1'b0;

    if (I_CLEAR) begin
      state_d = ST_IDLE;
      count_d = '0;
      ps_d    = '0;
    end else begin
      if (rate_change) begin
        ps_d = '0;
      end

      case (state_q)
        ST_IDLE: begin
          if (!I_PAUSE && I_START) begin
            state_d = ST_LOAD;
          end
        end

        ST_LOAD: begin
          count_d = I_LOAD_VAL;
          ps_d    = '0;
          if (I_LOAD_VAL == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end

        ST_RUN: begin
          if (I_PAUSE) begin
            state_d = ST_PAUSED;
          end else if (!rate_change) begin
            if (ps_q >= div_last) begin
              ps_d = '0;
              // The count never goes below zero; reaching zero ends the run.
              if (count_q != '0) begin
                tick_d  = 1'b1;
                count_d = count_q - WIDTH'(1);
              end
              if (count_q <= WIDTH'(1)) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end
            end else begin
              ps_d = ps_q + PS_W'(1);
            end
          end
        end

        ST_PAUSED: begin
          if (!I_PAUSE) begin
            state_d = ST_RUN;
          end
        end

        ST_DONE: begin
          count_d = '0;
          if (!I_PAUSE && (I_AUTO_RELOAD || I_START)) begin
            state_d = ST_LOAD;
          end
        end

        default: begin
          state_d = ST_IDLE;
          count_d = '0;
          ps_d    = '0;
        end
      endcase
    end

    busy_d = (state_d == ST_LOAD) || (state_d == ST_RUN) ||
             (state_d == ST_PAUSED);
  end

  // State and output registers. The rate copy resets to slow regardless of
  // I_M, so a fast selection at reset shows up as a rate change in IDLE,
  // where it is harmless.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      ps_q    <= '0;
      m_q     <= 1'b1;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ps_q    <= ps_d;
      m_q     <= m_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign O_COUNT = count_q;
  assign O_TICK  = tick_q;
  assign O_DONE  = done_q;
  assign O_BUSY  = busy_q;
  assign O_STATE = state_q;

endmodule

// File: tb/tb_down_count_ctrl.sv
// tb_down_count_ctrl
//   Bench for down_count_ctrl with SLOW_DIV=4 and FAST_DIV=2. A reference
//   model tracks state, count and "cycles left until the next tick". Each
//   scenario task compares the DUT against that model and against the fixed
//   timings expected for the scenario.

module tb_down_count_ctrl;

  localparam int WIDTH = 4;
  localparam int SLOW  = 4;
  localparam int FAST  = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             pause = 1'b0;
  logic             clear = 1'b0;
  logic             m = 1'b1;
  logic             auto_rl = 1'b0;
  logic [WIDTH-1:0] load_val = '0;

  logic [WIDTH-1:0] o_count;
  logic             o_tick;
  logic             o_done;
  logic             o_busy;
  logic [2:0]       o_state;
  logic [9:0]       act_vec;

  int checks = 0;
  int errors = 0;

  // Reference model: state number, count, cycles left until the next tick,
  // registered rate select and the two pulse outputs.
  int m_state;
  int m_count;
  int m_left;
  bit m_rate;
  bit m_tick;
  bit m_done;

  down_count_ctrl #(
    .WIDTH   (WIDTH),
    .SLOW_DIV(SLOW),
    .FAST_DIV(FAST),
    .PS_W    (32)
  ) dut (
    .I_CLK        (clk),
    .I_RST_N      (rst_n),
    .I_START      (start),
    .I_PAUSE      (pause),
    .I_CLEAR      (clear),
    .I_M          (m),
    .I_AUTO_RELOAD(auto_rl),
    .I_LOAD_VAL   (load_val),
    .O_COUNT      (o_count),
    .O_TICK       (o_tick),
    .O_DONE       (o_done),
    .O_BUSY       (o_busy),
    .O_STATE      (o_state)
  );

  assign act_vec = {o_count, o_tick, o_done, o_busy, o_state};

  always #5 clk = ~clk;

  // Guard against a hung run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int div_of(bit rate);
    return rate ? SLOW : FAST;
  endfunction

  function automatic logic [9:0] exp_vec();
    logic busy;
    busy = (m_state == 1) || (m_state == 2) || (m_state == 3);
    return {WIDTH'(m_count), m_tick, m_done, busy, 3'(m_state)};
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_count = 0;
    m_left  = 0;
    m_rate  = 1'b1;
    m_tick  = 1'b0;
    m_done  = 1'b0;
  endtask

  // One clock edge of the reference behaviour, using the inputs present at
  // that edge. A rate change restarts the wait with the new divider.
  task automatic model_step();
    bit chg;
    int nstate;
    chg    = (m_rate != m);
    nstate = m_state;
    m_tick = 1'b0;
    m_done = 1'b0;
    if (clear) begin
      nstate  = 0;
      m_count = 0;
    end else begin
      case (m_state)
        0: if (start && !pause) nstate = 1;
        1: begin
          m_count = int'(load_val);
          m_left  = div_of(m);
          if (load_val == 0) begin
            nstate = 4;
            m_done = 1'b1;
          end else begin
            nstate = 2;
          end
        end
        2: begin
          if (chg) begin
            m_left = div_of(m);
          end else if (!pause) begin
            if (m_left == 1) begin
              m_tick  = 1'b1;
              m_count = m_count - 1;
              m_left  = div_of(m);
              if (m_count == 0) begin
                nstate = 4;
                m_done = 1'b1;
              end
            end else begin
              m_left = m_left - 1;
            end
          end
          if (pause) nstate = 3;
        end
        3: begin
          if (chg) m_left = div_of(m);
          if (!pause) nstate = 2;
        end
        default: begin
          m_count = 0;
          if (!pause && (start || auto_rl)) nstate = 1;
        end
      endcase
    end
    m_state = nstate;
    m_rate  = m;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Reset release values, then an asynchronous reset in the middle of a run.
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if (act_vec !== 10'd0) begin
      errors++;
      $display("[TB] FAIL reset_values: actual {cnt,tick,done,busy,state}=%b required=%b", act_vec, 10'd0);
    end
    load_val = 4'd7;
    m = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL reset_prerun cyc%0d: actual=%b required=%b", i, act_vec, exp_vec());
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_count !== 4'd0 || o_state !== 3'd0 || o_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_async: actual count=%0d state=%0d busy=%b required count=0 state=0 busy=0", o_count, o_state, o_busy);
    end
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // Load 3 at the slow rate: ticks 4 cycles apart, done with the third tick.
  task automatic test_load_slow();
    int ticks[$];
    int dones[$];
    m = 1'b1;
    load_val = 4'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL load_slow cyc%0d: actual=%b required=%b", i, act_vec, exp_vec());
      end
      if (o_tick === 1'b1) ticks.push_back(i);
      if (o_done === 1'b1) dones.push_back(i);
    end
    checks++;
    if (ticks.size() != 3 || dones.size() != 1) begin
      errors++;
      $display("[TB] FAIL load_slow_pulses: actual ticks=%0d dones=%0d required ticks=3 dones=1", ticks.size(), dones.size());
    end else begin
      checks++;
      if (ticks[0] != 4 || ticks[1] != 8 || ticks[2] != 12 || dones[0] != 12) begin
        errors++;
        $display("[TB] FAIL load_slow_timing: actual ticks@%0d,%0d,%0d done@%0d required 4,8,12 done@12", ticks[0], ticks[1], ticks[2], dones[0]);
      end
    end
    checks++;
    if (o_state !== 3'd4 || o_busy !== 1'b0 || o_count !== 4'd0) begin
      errors++;
      $display("[TB] FAIL load_slow_end: actual state=%0d busy=%b count=%0d required 4,0,0", o_state, o_busy, o_count);
    end
  endtask

  // Load 5 at the fast rate, pause after the second tick, then resume. A
  // second short pause lands on a due tick, which must be deferred.
  task automatic test_pause();
    int nticks;
    int waited;
    m = 1'b0;
    load_val = 4'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    nticks = 0;
    waited = 0;
    while (nticks < 2 && waited < 40) begin
      step();
      waited++;
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL pause_prerun cyc%0d: actual=%b required=%b", waited, act_vec, exp_vec());
      end
      if (o_tick === 1'b1) nticks++;
    end
    checks++;
    if (nticks < 2) begin
      errors++;
      $display("[TB] FAIL pause_wait_ticks: actual ticks=%0d required 2 within 40 cycles", nticks);
    end
    pause = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if (act_vec !== exp_vec() || o_count !== 4'd3 || o_tick !== 1'b0) begin
        errors++;
        $display("[TB] FAIL pause_hold cyc%0d: actual=%b required=%b count 3 no tick", i, act_vec, exp_vec());
      end
    end
    pause = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (act_vec !== exp_vec() || o_tick !== (i == 3)) begin
        errors++;
        $display("[TB] FAIL pause_resume cyc%0d: actual=%b tick=%b required=%b tick=%b", i, act_vec, o_tick, exp_vec(), (i == 3));
      end
    end
    step();
    pause = 1'b1;
    step();
    pause = 1'b0;
    step();
    checks++;
    if (o_tick !== 1'b0 || o_state !== 3'd2) begin
      errors++;
      $display("[TB] FAIL pause_defer_wait: actual tick=%b state=%0d required tick=0 state=2", o_tick, o_state);
    end
    step();
    checks++;
    if (o_tick !== 1'b1 || o_count !== 4'd1 || act_vec !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL pause_defer_fire: actual tick=%b count=%0d required tick=1 count=1", o_tick, o_count);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL pause_finish cyc%0d: actual=%b required=%b", i, act_vec, exp_vec());
      end
    end
  endtask

  // Load 0: LOAD then DONE with exactly one done pulse and no ticks.
  task automatic test_load_zero();
    int nticks;
    int ndones;
    nticks = 0;
    ndones = 0;
    load_val = 4'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL load_zero cyc%0d: actual=%b required=%b", i, act_vec, exp_vec());
      end
      if (o_tick === 1'b1) nticks++;
      if (o_done === 1'b1) ndones++;
    end
    checks++;
    if (nticks != 0 || ndones != 1 || o_state !== 3'd4) begin
      errors++;
      $display("[TB] FAIL load_zero_pulses: actual ticks=%0d dones=%0d state=%0d required 0,1,4", nticks, ndones, o_state);
    end
  endtask

  // Auto reload of 2 at the fast rate: done every 6 cycles; then clear and
  // pause together return to IDLE.
  task automatic test_auto_reload();
    int dones[$];
    auto_rl = 1'b1;
    m = 1'b0;
    load_val = 4'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 26; i++) begin
      step();
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL auto_reload cyc%0d: actual=%b required=%b", i, act_vec, exp_vec());
      end
      if (o_done === 1'b1) dones.push_back(i);
    end
    checks++;
    if (dones.size() != 4) begin
      errors++;
      $display("[TB] FAIL auto_reload_count: actual dones=%0d required 4", dones.size());
    end else begin
      checks++;
      if (dones[0] != 4 || dones[1] != 10 || dones[2] != 16 || dones[3] != 22) begin
        errors++;
        $display("[TB] FAIL auto_reload_period: actual done@%0d,%0d,%0d,%0d required 4,10,16,22", dones[0], dones[1], dones[2], dones[3]);
      end
    end
    clear = 1'b1;
    pause = 1'b1;
    step();
    checks++;
    if (o_state !== 3'd0 || o_count !== 4'd0 || o_done !== 1'b0 || o_busy !== 1'b0 || act_vec !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL clear_pause: actual state=%0d count=%0d done=%b busy=%b required 0,0,0,0", o_state, o_count, o_done, o_busy);
    end
    clear = 1'b0;
    pause = 1'b0;
    auto_rl = 1'b0;
    step();
    checks++;
    if (o_state !== 3'd0 || act_vec !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL clear_stays_idle: actual state=%0d required 0", o_state);
    end
  endtask

  // Slow to fast while the prescaler sits at 2: no tick on the change edge,
  // next tick two cycles later.
  task automatic test_rate_change();
    int waited;
    m = 1'b1;
    load_val = 4'd9;
    start = 1'b1;
    step();
    start = 1'b0;
    waited = 0;
    do begin
      step();
      waited++;
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL rate_prerun cyc%0d: actual=%b required=%b", waited, act_vec, exp_vec());
      end
    end while (o_tick !== 1'b1 && waited < 20);
    checks++;
    if (o_tick !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rate_wait_tick: actual no tick in %0d cycles required one", waited);
    end
    repeat (2) step();
    m = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (o_tick !== (i == 3) || act_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL rate_change cyc%0d: actual tick=%b vec=%b required tick=%b vec=%b", i, o_tick, act_vec, (i == 3), exp_vec());
      end
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Random input sequences against the model.
  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      clear    = ($urandom_range(0, 39) == 0);
      pause    = ($urandom_range(0, 5) == 0);
      start    = ($urandom_range(0, 3) == 0);
      load_val = WIDTH'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) m = ~m;
      if ($urandom_range(0, 19) == 0) auto_rl = ~auto_rl;
      step();
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL random cyc%0d: actual=%b required=%b", i, act_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_slow();
    test_pause();
    test_load_zero();
    test_auto_reload();
    test_rate_change();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
